// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fetch_pkg                                                         |
// | Brief   : State and next-PC select encodings shared by the fetch sequencer. |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t C_RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_VALID = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JALR = 2'b01;
  localparam logic [1:0] SEL_TGT  = 2'b10;
  localparam logic [1:0] SEL_BAD  = 2'b11;

  // jal and a taken beq share the ExtOp target path; jalr alone uses ALUOut.
  function automatic logic [1:0] branch_sel(input logic zero, input logic beq,
                                            input logic jal, input logic jalr);
    return {(zero & beq) | jal, jalr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : next_pc_mux                                                        |
// | Brief  : Combinational next-PC select with illegal-select/alignment check.  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module next_pc_mux
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_zero,
  input  logic        i_branch_beq,
  input  logic        i_branch_jal,
  input  logic        i_branch_jalr,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_ext_op,
  output logic [31:0] o_next_pc,
  output logic        o_bad_target
);

  logic [1:0] w_sel;

  assign w_sel = branch_sel(i_zero, i_branch_beq, i_branch_jal, i_branch_jalr);

  always_comb begin
    o_next_pc    = i_pc + 32'd4;
    o_bad_target = 1'b0;
    case (w_sel)
      SEL_JALR: begin
        o_next_pc    = i_alu_out;
        o_bad_target = |i_alu_out[1:0];
      end
      SEL_TGT: begin
        o_next_pc    = i_ext_op;
        o_bad_target = |i_ext_op[1:0];
      end
      SEL_BAD: begin
        o_next_pc    = i_pc;
        o_bad_target = 1'b1;
      end
      default: begin
        o_next_pc    = i_pc + 32'd4;
        o_bad_target = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fetch_sequencer                                                    |
// | Brief  : Owns the PC, runs one-outstanding imem fetches, hands words to     |
// |          decode with valid/stall and resolves the next PC.                  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = C_RESET_PC_DEFAULT,
  parameter int          WAIT_LIMIT = 15,
  parameter int          CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  input  logic        stall,
  input  logic        zero,
  input  logic        BranchBeq,
  input  logic        BranchJal,
  input  logic        BranchJalr,
  input  logic [31:0] ALUOut,
  input  logic [31:0] ExtOp,
  input  logic        halt_req,
  output logic        fetch_err
);

  logic [2:0]       r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc_out;
  logic             r_valid;
  logic             r_err;

  logic [31:0]      w_next_pc;
  logic             w_bad_target;
  logic [CNT_W-1:0] w_cnt_nxt;

  next_pc_mux u_next_pc_mux (
    .i_pc          (r_pc),
    .i_zero        (zero),
    .i_branch_beq  (BranchBeq),
    .i_branch_jal  (BranchJal),
    .i_branch_jalr (BranchJalr),
    .i_alu_out     (ALUOut),
    .i_ext_op      (ExtOp),
    .o_next_pc     (w_next_pc),
    .o_bad_target  (w_bad_target)
  );

  assign w_cnt_nxt = r_wait_cnt + CNT_W'(1);

  // Request is decoded from state so an async reset drops it at once.
  assign imem_req    = (r_state == ST_REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign Instruction = r_instr;
  assign PC          = r_pc_out;
  assign fetch_err   = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_wait_cnt <= '0;
      r_instr    <= 32'h0;
      r_pc_out   <= RESET_PC;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= halt_req ? ST_HALT : ST_REQ;
        end
        ST_REQ: begin
          if (imem_ready) begin
            r_instr    <= imem_rdata;
            r_pc_out   <= r_pc;
            r_valid    <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= ST_VALID;
          end else begin
            r_wait_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_W'(WAIT_LIMIT)) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        ST_VALID: begin
          // Branch controls only matter on the cycle decode consumes the word.
          if (!stall) begin
            r_valid <= 1'b0;
            if (w_bad_target) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= halt_req ? ST_HALT : ST_REQ;
            end
          end
        end
        ST_HALT: begin
          if (!halt_req) begin
            r_state <= ST_REQ;
          end
        end
        ST_ERR: begin
          r_err   <= 1'b1;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_ERR;
          r_err   <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fetch_sequencer                                                 |
// | Brief  : Scoreboard bench for fetch_sequencer with a simple imem model.     |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam logic [31:0] C_MAGIC = 32'hA5A5_5A5A;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        stall;
  logic        zero;
  logic        BranchBeq;
  logic        BranchJal;
  logic        BranchJalr;
  logic [31:0] ALUOut;
  logic [31:0] ExtOp;
  logic        halt_req;
  logic        fetch_err;
  logic        mem_en;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;
  logic pend       = 1'b0;
  int   req_cycles;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .Instruction (Instruction),
    .PC          (PC),
    .stall       (stall),
    .zero        (zero),
    .BranchBeq   (BranchBeq),
    .BranchJal   (BranchJal),
    .BranchJalr  (BranchJalr),
    .ALUOut      (ALUOut),
    .ExtOp       (ExtOp),
    .halt_req    (halt_req),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // imem answers in the same cycle it sees a request; data is address-tagged.
  assign imem_ready = mem_en & imem_req;
  assign imem_rdata = imem_addr ^ C_MAGIC;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ C_MAGIC;
    q.push_back(e);
  endtask

  // Monitor: each new word on the decode side is matched against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      pend       = 1'b0;
    end else begin
      if (pend) check32("valid_latency", {31'b0, instr_valid}, 32'd1);
      pend = imem_req & imem_ready;
      if (instr_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h required=none", PC);
        end else begin
          mon_e = q.pop_front();
          check32("fetch_pc", PC, mon_e.pc);
          check32("fetch_instr", Instruction, mon_e.instr);
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout actual=no_valid required=valid", name);
  endtask

  task automatic consume(input logic z, input logic beq, input logic jal, input logic jalr,
                         input logic [31:0] alu, input logic [31:0] ext);
    zero       = z;
    BranchBeq  = beq;
    BranchJal  = jal;
    BranchJalr = jalr;
    ALUOut     = alu;
    ExtOp      = ext;
    stall      = 1'b0;
    @(negedge clk);
    stall      = 1'b1;
    zero       = 1'b0;
    BranchBeq  = 1'b0;
    BranchJal  = 1'b0;
    BranchJalr = 1'b0;
    ALUOut     = 32'h0;
    ExtOp      = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; mem_en = 1'b1; stall = 1'b1; halt_req = 1'b0;
    zero = 1'b0; BranchBeq = 1'b0; BranchJal = 1'b0; BranchJalr = 1'b0;
    ALUOut = 32'h0; ExtOp = 32'h0;
    repeat (2) @(negedge clk);

    check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check32("rst_imem_addr", imem_addr, 32'h0);
    check32("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check32("rst_instruction", Instruction, 32'h0);
    check32("rst_pc", PC, 32'h0);
    check32("rst_fetch_err", {31'b0, fetch_err}, 32'd0);

    // Sequential stream 0,4,8,C.
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    reset = 1'b1;
    wait_valid("seq0"); consume(0, 0, 0, 0, 32'h0, 32'h0);
    wait_valid("seq4"); consume(0, 0, 0, 0, 32'h0, 32'h0);
    wait_valid("seq8"); consume(0, 0, 0, 0, 32'h0, 32'h0);
    wait_valid("seqC");

    // Taken beq, then not-taken beq.
    push(32'h40);
    consume(1, 1, 0, 0, 32'h0, 32'h40);
    wait_valid("beq_taken");
    push(32'h44);
    consume(0, 1, 0, 0, 32'h0, 32'h80);
    wait_valid("beq_not_taken");

    // Stall hold.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("stall_valid", {31'b0, instr_valid}, 32'd1);
      check32("stall_pc", PC, 32'h44);
      check32("stall_instr", Instruction, 32'h44 ^ C_MAGIC);
      check32("stall_req", {31'b0, imem_req}, 32'd0);
      check32("stall_addr", imem_addr, 32'h44);
    end

    // jal and jalr targets, then wrap and halt.
    push(32'h100);
    consume(0, 0, 1, 0, 32'h0, 32'h100);
    wait_valid("jal");
    push(32'h200);
    consume(0, 0, 0, 1, 32'h200, 32'h0);
    wait_valid("jalr");
    push(32'hFFFF_FFFC);
    consume(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    wait_valid("jalr_top");
    halt_req = 1'b1;
    consume(0, 0, 0, 0, 32'h0, 32'h0);
    check32("halt_req_low", {31'b0, imem_req}, 32'd0);
    check32("halt_valid_low", {31'b0, instr_valid}, 32'd0);
    check32("wrap_addr", imem_addr, 32'h0);
    repeat (3) @(negedge clk);
    check32("halt_hold_req", {31'b0, imem_req}, 32'd0);
    check32("halt_no_err", {31'b0, fetch_err}, 32'd0);
    push(32'h0);
    halt_req = 1'b0;
    wait_valid("halt_release");

    // Illegal select: jal and jalr together.
    consume(0, 0, 1, 1, 32'h8, 32'h10);
    check32("bad_sel_err", {31'b0, fetch_err}, 32'd1);
    check32("bad_sel_req", {31'b0, imem_req}, 32'd0);
    check32("bad_sel_valid", {31'b0, instr_valid}, 32'd0);
    check32("bad_sel_pc_kept", imem_addr, 32'h0);
    repeat (3) @(negedge clk);
    check32("bad_sel_sticky", {31'b0, fetch_err}, 32'd1);
    check32("bad_sel_no_req", {31'b0, imem_req}, 32'd0);

    // Misaligned jalr target.
    push(32'h0);
    do_reset();
    wait_valid("misalign_pre");
    consume(0, 0, 0, 1, 32'h42, 32'h0);
    check32("misalign_err", {31'b0, fetch_err}, 32'd1);
    check32("misalign_pc_kept", imem_addr, 32'h0);

    // imem never ready: error after WAIT_LIMIT request cycles.
    mem_en = 1'b0;
    do_reset();
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fetch_err) break;
      if (imem_req) req_cycles++;
    end
    check32("timeout_err", {31'b0, fetch_err}, 32'd1);
    check32("timeout_req_cycles", req_cycles, 32'd15);
    mem_en = 1'b1;
    repeat (4) @(negedge clk);
    check32("timeout_sticky", {31'b0, fetch_err}, 32'd1);
    check32("timeout_no_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    check32("reset_clears_err", {31'b0, fetch_err}, 32'd0);

    // Reset mid-request drops imem_req immediately.
    mem_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check32("midreq_req_high", {31'b0, imem_req}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check32("midreq_req_dropped", {31'b0, imem_req}, 32'd0);
    check32("midreq_addr", imem_addr, 32'h0);
    @(negedge clk);
    check32("midreq_no_valid", {31'b0, instr_valid}, 32'd0);

    check32("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
